// File: rtl/perf_pkg.sv
// Shared types and constants for the CPU-to-peripheral bridge.
// Holds the FSM state encoding, default window/error constants and width helpers.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [63:0] ERR_DATA_DEFAULT = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [31:0] WIN_TAG_DEFAULT  = 32'd1;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  // A single channel still needs a one-bit index field.
  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : clog2(num_ch);
  endfunction

endpackage

// File: rtl/perf_bridge_if.sv
// CPU-side and peripheral-side signal bundle of the bridge.
// master = CPU plus peripherals (environment), slave = the bridge itself.
interface perf_bridge_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int NUM_CH = 4
);
  logic                     memreg;
  logic                     wren;
  logic [ADDR_W-1:0]        addr_in;
  logic [DATA_W-1:0]        data_in;
  logic                     cpu_stall;
  logic [DATA_W-1:0]        cpu_rdata;
  logic                     cpu_rvalid;
  logic                     cpu_err;
  logic [NUM_CH-1:0]        perf_en;
  logic [ADDR_W-1:0]        perf_addr_out;
  logic [DATA_W-1:0]        perf_data_out;
  logic                     perf_wren;
  logic [NUM_CH*DATA_W-1:0] perf_rdata;
  logic [NUM_CH-1:0]        perf_ack;

  modport master (
    output memreg, wren, addr_in, data_in, perf_rdata, perf_ack,
    input  cpu_stall, cpu_rdata, cpu_rvalid, cpu_err,
    input  perf_en, perf_addr_out, perf_data_out, perf_wren
  );

  modport slave (
    input  memreg, wren, addr_in, data_in, perf_rdata, perf_ack,
    output cpu_stall, cpu_rdata, cpu_rvalid, cpu_err,
    output perf_en, perf_addr_out, perf_data_out, perf_wren
  );

endinterface

// File: rtl/perf_decode.sv
// Combinational address decode: window hit, channel index, range check and
// one-hot channel select.
module perf_decode
  import perf_pkg::*;
#(
  parameter int                 ADDR_W  = 64,
  parameter int                 NUM_CH  = 4,
  parameter logic [ADDR_W-33:0] WIN_TAG = (ADDR_W-32)'(WIN_TAG_DEFAULT),
  parameter int                 CH_LSB  = 8,
  localparam int                CH_W    = ch_width(NUM_CH)
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              memreg_i,
  input  logic              wren_i,
  output logic              hit_o,
  output logic [CH_W-1:0]   ch_o,
  output logic              ch_valid_o,
  output logic [NUM_CH-1:0] sel_o
);

  logic unused_addr_bits;

  assign hit_o      = (addr_i[ADDR_W-1:32] == WIN_TAG) && (memreg_i || wren_i);
  assign ch_o       = addr_i[CH_LSB +: CH_W];
  assign ch_valid_o = ({1'b0, ch_o} < (CH_W+1)'(NUM_CH));

  // Offset bits below the window tag are forwarded by the top, not decoded here.
  assign unused_addr_bits = ^addr_i;

  always_comb begin
    // NOTE: default first so every path assigns sel_o and no latch is inferred.
    sel_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_o[i] = ch_valid_o && (ch_o == CH_W'(i));
    end
  end

endmodule

// File: rtl/perf_bridge.sv
// Stalling CPU-to-peripheral bridge: decode, hold the access on one channel
// until it acks, return read data. Define PERF_TIMEOUT_EN to abort hung accesses.
module perf_bridge
  import perf_pkg::*;
#(
  parameter int                 ADDR_W   = 64,
  parameter int                 DATA_W   = 64,
  parameter int                 NUM_CH   = 4,
  parameter logic [ADDR_W-33:0] WIN_TAG  = (ADDR_W-32)'(WIN_TAG_DEFAULT),
  parameter int                 CH_LSB   = 8,
  parameter int                 TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]  ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input logic          clk,
  input logic          rst,
  perf_bridge_if.slave bus
);

  localparam int CH_W = ch_width(NUM_CH);

  logic              hit;
  logic [CH_W-1:0]   ch;
  logic              ch_valid;
  logic [NUM_CH-1:0] sel;

  state_e            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [NUM_CH-1:0] en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              err_q;

  logic              ack_sel;
  logic [DATA_W-1:0] rdata_sel;
  logic              timeout_hit;

  perf_decode #(
    .ADDR_W (ADDR_W),
    .NUM_CH (NUM_CH),
    .WIN_TAG(WIN_TAG),
    .CH_LSB (CH_LSB)
  ) u_decode (
    .addr_i    (bus.addr_in),
    .memreg_i  (bus.memreg),
    .wren_i    (bus.wren),
    .hit_o     (hit),
    .ch_o      (ch),
    .ch_valid_o(ch_valid),
    .sel_o     (sel)
  );

  // Only the channel owning the access can complete it.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        ack_sel   = bus.perf_ack[i];
        rdata_sel = bus.perf_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef PERF_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  // cnt_q counts completed BUSY cycles, so the last allowed one sees TIMEOUT-1.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (!rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      en_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef PERF_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hit) begin
            if (ch_valid) begin
              state_q <= BUSY;
              ch_q    <= ch;
              en_q    <= sel;
              addr_q  <= bus.addr_in;
              data_q  <= bus.data_in;
              wr_q    <= bus.wren;
`ifdef PERF_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
              err_q    <= 1'b1;
              rdata_q  <= ERR_DATA;
            end
          end
        end
        BUSY: begin
          // An ack coinciding with the timeout still completes normally.
          if (ack_sel || timeout_hit) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            err_q    <= !ack_sel;
            rdata_q  <= !ack_sel ? ERR_DATA : (wr_q ? '0 : rdata_sel);
            en_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
          end
`ifdef PERF_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall releases in RESP so the CPU consumes cpu_rdata alongside cpu_rvalid.
  assign bus.cpu_stall     = (state_q == BUSY) || ((state_q == IDLE) && hit);
  assign bus.cpu_rdata     = rdata_q;
  assign bus.cpu_rvalid    = rvalid_q;
  assign bus.cpu_err       = err_q;
  assign bus.perf_en       = en_q;
  assign bus.perf_addr_out = addr_q;
  assign bus.perf_data_out = data_q;
  assign bus.perf_wren     = wr_q;

endmodule

// File: tb/tb_perf_bridge.sv
// Scenario bench for perf_bridge with three channels (so channel index 3 is a
// decode error); expected completions go through a scoreboard queue.
module tb_perf_bridge;

  localparam int          AW   = 64;
  localparam int          DW   = 64;
  localparam int          NCH  = 3;
  localparam logic [63:0] ERRD = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    errors = 0;
  int    checks = 0;
  resp_t sb[$];
  resp_t exp_r;

  perf_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH)) bus ();

  perf_bridge #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .NUM_CH  (NCH),
    .WIN_TAG (32'd1),
    .CH_LSB  (8),
    .TIMEOUT (4),
    .ERR_DATA(ERRD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.cpu_rvalid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got rvalid with rdata=%h err=%b, required no completion",
                 bus.cpu_rdata, bus.cpu_err);
      end else begin
        exp_r = sb.pop_front();
        if ({bus.cpu_rdata, bus.cpu_err} !== {exp_r.data, exp_r.err}) begin
          errors++;
          $display("FAIL sb_resp: got rdata=%h err=%b, required rdata=%h err=%b",
                   bus.cpu_rdata, bus.cpu_err, exp_r.data, exp_r.err);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.memreg     = 1'b0;
    bus.wren       = 1'b0;
    bus.addr_in    = '0;
    bus.data_in    = '0;
    bus.perf_ack   = '0;
    bus.perf_rdata = '0;
  endtask

  task automatic wait_rvalid(input int budget, output int cyc);
    cyc = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (bus.cpu_rvalid === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.perf_en, bus.perf_wren, bus.cpu_rvalid, bus.cpu_err, bus.cpu_stall,
         bus.cpu_rdata, bus.perf_addr_out, bus.perf_data_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b wren=%b rvalid=%b err=%b stall=%b rdata=%h, required all 0",
               bus.perf_en, bus.perf_wren, bus.cpu_rvalid, bus.cpu_err, bus.cpu_stall, bus.cpu_rdata);
    end
    rst = 1'b1;
  endtask

  task automatic test_non_window();
    bus.memreg  = 1'b1;
    bus.addr_in = 64'h2_0000_0000;
    #1;
    checks++;
    if (bus.cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL nonwin_stall: got %b, required 0", bus.cpu_stall);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.perf_en, bus.perf_wren, bus.cpu_rvalid, bus.cpu_stall,
           bus.perf_addr_out, bus.cpu_rdata} !== '0) begin
        errors++;
        $display("FAIL nonwin_quiet: en=%b rvalid=%b stall=%b addr=%h rdata=%h, required all 0",
                 bus.perf_en, bus.cpu_rvalid, bus.cpu_stall, bus.perf_addr_out, bus.cpu_rdata);
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_read();
    sb.push_back('{data: 64'h1234, err: 1'b0});
    bus.memreg  = 1'b1;
    bus.addr_in = 64'h1_0000_0100;
    #1;
    checks++;
    if (bus.cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL read_hit_stall: got %b, required 1", bus.cpu_stall);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.perf_en, bus.cpu_stall, bus.perf_wren, bus.cpu_rvalid} !== {3'b010, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL read_busy%0d: en=%b stall=%b wren=%b rvalid=%b, required en=010 stall=1 wren=0 rvalid=0",
                 k, bus.perf_en, bus.cpu_stall, bus.perf_wren, bus.cpu_rvalid);
      end
      checks++;
      if (bus.perf_addr_out !== 64'h1_0000_0100) begin
        errors++;
        $display("FAIL read_addr%0d: got %h, required 0000000100000100", k, bus.perf_addr_out);
      end
      bus.perf_ack = '0;
      if (k == 1) begin
        bus.perf_ack[0]         = 1'b1;
        bus.perf_rdata[0 +: DW] = 64'h9999;
      end
      if (k == 3) begin
        bus.perf_ack[1]          = 1'b1;
        bus.perf_rdata[DW +: DW] = 64'h1234;
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_stall, bus.perf_en} !== {1'b1, 1'b0, 3'b000}) begin
      errors++;
      $display("FAIL read_resp: rvalid=%b stall=%b en=%b, required rvalid=1 stall=0 en=000",
               bus.cpu_rvalid, bus.cpu_stall, bus.perf_en);
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 64'h1234}) begin
      errors++;
      $display("FAIL read_hold: rvalid=%b rdata=%h, required rvalid=0 rdata=1234",
               bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  task automatic test_write();
    sb.push_back('{data: 64'h0, err: 1'b0});
    bus.memreg              = 1'b1;
    bus.wren                = 1'b1;
    bus.addr_in             = 64'h1_0000_0000;
    bus.data_in             = 64'hABCD;
    bus.perf_ack[0]         = 1'b1;
    bus.perf_rdata[0 +: DW] = 64'hFFFF;
    @(negedge clk);
    checks++;
    if ({bus.perf_en, bus.perf_wren, bus.perf_data_out} !== {3'b001, 1'b1, 64'hABCD}) begin
      errors++;
      $display("FAIL write_busy: en=%b wren=%b data=%h, required en=001 wren=1 data=abcd",
               bus.perf_en, bus.perf_wren, bus.perf_data_out);
    end
    @(negedge clk);
    checks++;
    if ({bus.cpu_rvalid, bus.perf_wren, bus.perf_data_out} !== {1'b1, 1'b0, 64'h0}) begin
      errors++;
      $display("FAIL write_resp: rvalid=%b wren=%b data=%h, required rvalid=1 wren=0 data=0",
               bus.cpu_rvalid, bus.perf_wren, bus.perf_data_out);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus.perf_ack[2]            = 1'b1;
    bus.perf_rdata[2*DW +: DW] = 64'h5555;
    for (int i = 0; i < 2; i++) begin
      sb.push_back((i == 0) ? '{data: 64'h5555, err: 1'b0} : '{data: 64'h0, err: 1'b0});
      bus.memreg  = (i == 0);
      bus.wren    = (i == 1);
      bus.addr_in = 64'h1_0000_0200;
      bus.data_in = 64'h77;
      wait_rvalid(10, cyc);
      checks++;
      if (cyc !== 2) begin
        errors++;
        $display("FAIL b2b_latency%0d: got %0d cycles (0 = none), required 2", i, cyc);
      end
      bus.memreg = 1'b0;
      bus.wren   = 1'b0;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_decode_error();
    sb.push_back('{data: ERRD, err: 1'b1});
    bus.memreg  = 1'b1;
    bus.addr_in = 64'h1_0000_0300;
    #1;
    checks++;
    if (bus.cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL decerr_stall: got %b, required 1", bus.cpu_stall);
    end
    @(negedge clk);
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_err, bus.perf_en} !== {1'b1, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL decerr_resp: rvalid=%b err=%b en=%b, required rvalid=1 err=1 en=000",
               bus.cpu_rvalid, bus.cpu_err, bus.perf_en);
    end
    idle_inputs();
    @(negedge clk);
  endtask

`ifdef PERF_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    sb.push_back('{data: ERRD, err: 1'b1});
    bus.memreg  = 1'b1;
    bus.addr_in = 64'h1_0000_0100;
    wait_rvalid(20, cyc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles (0 = none), required 5", cyc);
    end
    idle_inputs();
    @(negedge clk);
    sb.push_back('{data: 64'h4444, err: 1'b0});
    bus.memreg  = 1'b1;
    bus.addr_in = 64'h1_0000_0100;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin
        bus.perf_ack[1]          = 1'b1;
        bus.perf_rdata[DW +: DW] = 64'h4444;
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_err} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_ack_wins: rvalid=%b err=%b, required rvalid=1 err=0",
               bus.cpu_rvalid, bus.cpu_err);
    end
    idle_inputs();
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_busy();
    sb.push_back('{data: 64'h0, err: 1'b0});
    bus.memreg  = 1'b1;
    bus.addr_in = 64'h1_0000_0100;
    @(negedge clk);
    checks++;
    if (bus.perf_en !== 3'b010) begin
      errors++;
      $display("FAIL rstmid_busy: en=%b, required 010", bus.perf_en);
    end
    rst = 1'b0;
    idle_inputs();
    sb.delete();
    @(negedge clk);
    checks++;
    if ({bus.perf_en, bus.perf_wren, bus.cpu_rvalid, bus.cpu_err, bus.cpu_stall,
         bus.cpu_rdata, bus.perf_addr_out, bus.perf_data_out} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: en=%b rvalid=%b stall=%b addr=%h rdata=%h, required all 0",
               bus.perf_en, bus.cpu_rvalid, bus.cpu_stall, bus.perf_addr_out, bus.cpu_rdata);
    end
    rst                      = 1'b1;
    bus.perf_ack[1]          = 1'b1;
    bus.perf_rdata[DW +: DW] = 64'hBAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.cpu_rvalid, bus.cpu_stall, bus.perf_en} !== '0) begin
        errors++;
        $display("FAIL rstmid_stale_ack: rvalid=%b stall=%b en=%b, required all 0",
                 bus.cpu_rvalid, bus.cpu_stall, bus.perf_en);
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_non_window();
    test_read();
    test_write();
    test_back_to_back();
    test_decode_error();
`ifdef PERF_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_busy();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d completions outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
